chunker_stream: RTL and testbench

- Next-generation L-to-M bit chunker. It splits each L-bit input word into up to L/M chunks of M bits.
- Adds features the previous block lacks:
  - input buffering, so data_in need not be held constant;
  - a valid/ready handshake on both sides, with downstream backpressure;
  - selectable chunk order;
  - per-word chunk count;
  - a last-chunk marker.
- Sits between a wide producer (e.g. Toeplitz hash output) and a narrow serial consumer (FIFO/UART/USB packer).

---
 rtl/chunker_pkg.sv | 19 +
 rtl/chunker_stream.sv | 115 +++++++++++
 tb/tb_chunker_stream.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunker_pkg.sv
// chunker_pkg: shared sizing helpers and length rule for the chunker_stream block.
package chunker_pkg;

  // Number of M-bit chunks that fit in one L-bit word.
  function automatic int calc_nr(input int l, input int m);
    return l / m;
  endfunction

  // Width needed to express a chunk count of 0..NR.
  function automatic int calc_cw(input int l, input int m);
    return $clog2((l / m) + 1);
  endfunction

  // A requested length of zero, or one beyond the word, means the whole word.
  function automatic int eff_len(input int in_len, input int nr);
    return ((in_len == 0) || (in_len > nr)) ? nr : in_len;
  endfunction

endpackage

// File: rtl/chunker_stream.sv
// chunker_stream: splits L-bit words into M-bit chunks with a two-entry input
// buffer (ACT shifter + HOLD slot), valid/ready on both sides and a last marker.
module chunker_stream
  import chunker_pkg::*;
#(
  parameter int L = 128,
  parameter int M = 32,
  parameter bit MSB_FIRST = 1'b1,
  localparam int NR = calc_nr(L, M),
  localparam int CW = calc_cw(L, M)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [L-1:0]  data_in,
  input  logic [CW-1:0] in_len,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [M-1:0]  q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy
);

  if ((M < 1) || (M > L) || ((L % M) != 0)) begin : g_bad_params
    $error("chunker_stream: L must be a positive integer multiple of M");
  end

  logic [L-1:0]  act_sr, act_sr_nxt;
  logic [L-1:0]  act_shifted;
  logic [CW-1:0] rem, rem_nxt;
  logic          act_full, act_full_nxt;
  logic [L-1:0]  hold_data, hold_data_nxt;
  logic [CW-1:0] hold_len, hold_len_nxt;
  logic          hold_full, hold_full_nxt;
  logic          ready_q;
  logic [CW-1:0] in_len_eff;
  logic          in_fire;
  logic          out_fire;
  logic          word_done;

  assign in_len_eff  = CW'(eff_len(int'(in_len), NR));
  assign in_fire     = in_valid && ready_q;
  assign out_fire    = act_full && out_ready;
  assign word_done   = out_fire && (rem == CW'(1));
  assign act_shifted = MSB_FIRST ? (act_sr << M) : (act_sr >> M);

  // Decide where each word lives next cycle: shift ACT, refill it from HOLD or the input, or park the input in HOLD.
  always_comb begin
    act_sr_nxt    = act_sr;
    rem_nxt       = rem;
    act_full_nxt  = act_full;
    hold_data_nxt = hold_data;
    hold_len_nxt  = hold_len;
    hold_full_nxt = hold_full;
    if (word_done) begin
      if (hold_full) begin
        act_sr_nxt    = hold_data;
        rem_nxt       = hold_len;
        hold_full_nxt = 1'b0;
      end else if (in_fire) begin
        act_sr_nxt = data_in;
        rem_nxt    = in_len_eff;
      end else begin
        act_sr_nxt   = '0;
        rem_nxt      = '0;
        act_full_nxt = 1'b0;
      end
    end else begin
      if (out_fire) begin
        act_sr_nxt = act_shifted;
        rem_nxt    = rem - CW'(1);
      end
      if (in_fire) begin
        if (!act_full) begin
          act_sr_nxt   = data_in;
          rem_nxt      = in_len_eff;
          act_full_nxt = 1'b1;
        end else begin
          hold_data_nxt = data_in;
          hold_len_nxt  = in_len_eff;
          hold_full_nxt = 1'b1;
        end
      end
    end
  end

  // Register both entries; in_ready is a flop so it never depends on out_ready in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_sr    <= '0;
      rem       <= '0;
      act_full  <= 1'b0;
      hold_data <= '0;
      hold_len  <= '0;
      hold_full <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      act_sr    <= act_sr_nxt;
      rem       <= rem_nxt;
      act_full  <= act_full_nxt;
      hold_data <= hold_data_nxt;
      hold_len  <= hold_len_nxt;
      hold_full <= hold_full_nxt;
      ready_q   <= !hold_full_nxt;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = act_full;
  assign out_last  = act_full && (rem == CW'(1));
  assign busy      = act_full || hold_full;
  assign q         = !act_full ? '0 : (MSB_FIRST ? act_sr[L-1 -: M] : act_sr[M-1:0]);

endmodule

// File: tb/tb_chunker_stream.sv
// tb_chunker_stream: drives two chunker_stream instances (MSB-first and LSB-first)
// with identical stimulus and checks both against vector tables and a word-queue model.
module tb_chunker_stream;
  import chunker_pkg::*;

  localparam int L  = 128;
  localparam int M  = 32;
  localparam int NR = calc_nr(L, M);
  localparam int CW = calc_cw(L, M);

  localparam logic [L-1:0] WORD_T1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [L-1:0] WORD_A  = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [L-1:0] WORD_B  = 128'h10000001_20000002_30000003_40000004;
  localparam logic [L-1:0] WORD_D  = 128'hDDDD0001_DDDD0002_DDDD0003_DDDD0004;

  logic          clk;
  logic          reset_n;
  logic [L-1:0]  data_in;
  logic [CW-1:0] in_len;
  logic          in_valid;
  logic          out_ready;
  logic [M-1:0]  q_m, q_l;
  logic          out_valid_m, out_valid_l;
  logic          out_last_m, out_last_l;
  logic          in_ready_m, in_ready_l;
  logic          busy_m, busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words in flight, oldest first, each with its effective length and chunks already sent.
  typedef struct {
    logic [L-1:0] data;
    int           len;
    int           sent;
  } word_t;
  word_t words[$];
  logic  m_ready;

  typedef struct {
    string         name;
    logic          in_valid;
    logic [L-1:0]  data;
    logic [CW-1:0] len;
    logic          out_ready;
    logic          exp_valid;
    logic [M-1:0]  exp_q_msb;
    logic [M-1:0]  exp_q_lsb;
    logic          exp_last;
    logic          exp_ready;
    logic          exp_busy;
  } vec_t;
  vec_t vecs[$];

  chunker_stream #(.L(L), .M(M), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready_m), .q(q_m), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_last(out_last_m), .busy(busy_m)
  );

  chunker_stream #(.L(L), .M(M), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready_l), .q(q_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_last(out_last_l), .busy(busy_l)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chunk number idx of a word in emit order.
  function automatic logic [M-1:0] chunk_of(input logic [L-1:0] d, input int idx, input bit msb);
    if (msb) return d[L-1-idx*M -: M];
    return d[idx*M +: M];
  endfunction

  task automatic checkOutput(input string name, input logic ev, input logic [M-1:0] eqm,
                             input logic [M-1:0] eql, input logic el, input logic er, input logic eb);
    n_checks++;
    if ({out_valid_m, q_m, out_last_m, in_ready_m, busy_m} !== {ev, eqm, el, er, eb}) begin
      n_fail++;
      $display("[TB] FAIL %s msb: got valid/q/last/ready/busy=%b/%h/%b/%b/%b expected %b/%h/%b/%b/%b",
               name, out_valid_m, q_m, out_last_m, in_ready_m, busy_m, ev, eqm, el, er, eb);
    end
    n_checks++;
    if ({out_valid_l, q_l, out_last_l, in_ready_l, busy_l} !== {ev, eql, el, er, eb}) begin
      n_fail++;
      $display("[TB] FAIL %s lsb: got valid/q/last/ready/busy=%b/%h/%b/%b/%b expected %b/%h/%b/%b/%b",
               name, out_valid_l, q_l, out_last_l, in_ready_l, busy_l, ev, eql, el, er, eb);
    end
  endtask

  task automatic checkModel(input string name);
    logic         ev, el;
    logic [M-1:0] qm, ql;
    ev = (words.size() > 0);
    qm = '0;
    ql = '0;
    el = 1'b0;
    if (ev) begin
      qm = chunk_of(words[0].data, words[0].sent, 1'b1);
      ql = chunk_of(words[0].data, words[0].sent, 1'b0);
      el = (words[0].sent == words[0].len - 1);
    end
    checkOutput(name, ev, qm, ql, el, m_ready, ev);
  endtask

  // Drive one cycle of inputs, advance the model across the clock edge, return whether a word was taken.
  task automatic applyStimulus(input logic iv, input logic [L-1:0] d, input logic [CW-1:0] len,
                               input logic ordy, output bit accepted);
    bit    ofire, ifire;
    word_t w;
    in_valid  = iv;
    data_in   = d;
    in_len    = len;
    out_ready = ordy;
    ofire = (words.size() > 0) && ordy;
    ifire = iv && m_ready;
    @(posedge clk);
    if (ofire) begin
      w = words[0];
      w.sent++;
      if (w.sent == w.len) words.delete(0);
      else words[0] = w;
    end
    if (ifire) begin
      w.data = d;
      w.len  = eff_len(int'(len), NR);
      w.sent = 0;
      words.push_back(w);
    end
    m_ready  = (words.size() < 2);
    accepted = ifire;
    @(negedge clk);
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    in_len    = '0;
    words.delete();
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic drain(input string name, input int limit);
    bit acc;
    int cycles;
    cycles = 0;
    while ((words.size() > 0) && (cycles < limit)) begin
      checkModel(name);
      applyStimulus(1'b0, '0, '0, 1'b1, acc);
      cycles++;
    end
    if (words.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got %0d words pending, expected 0", name, words.size());
    end
    checkModel({name, "_idle"});
  endtask

  // Watchdog so a stuck run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: vector table, back-to-back, backpressure, random traffic, mid-word reset.
  initial begin
    bit           acc;
    int           idx, run, cyc;
    bit           started, stopped, saw_ready_low;
    logic [L-1:0] wl[3];
    logic [L-1:0] rd;
    logic         pat[3];

    doReset();
    checkModel("post_release");
    applyStimulus(1'b0, '0, '0, 1'b1, acc);

    vecs.push_back('{"t1_idle",    1'b1, WORD_T1, 3'd0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0});
    vecs.push_back('{"t1_c0",      1'b0, '0,      3'd0, 1'b1, 1'b1, 32'h00112233, 32'hCCDDEEFF, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"t1_c1",      1'b0, '0,      3'd0, 1'b1, 1'b1, 32'h44556677, 32'h8899AABB, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"t1_c2",      1'b0, '0,      3'd0, 1'b1, 1'b1, 32'h8899AABB, 32'h44556677, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"t1_c3",      1'b0, '0,      3'd0, 1'b1, 1'b1, 32'hCCDDEEFF, 32'h00112233, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"t1_done",    1'b1, WORD_A,  3'd2, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0});
    vecs.push_back('{"t5_a0",      1'b1, WORD_B,  3'd5, 1'b1, 1'b1, 32'hA0A1A2A3, 32'hD0D1D2D3, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"t5_a1",      1'b0, '0,      3'd0, 1'b1, 1'b1, 32'hB0B1B2B3, 32'hC0C1C2C3, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{"t5_b0",      1'b0, '0,      3'd0, 1'b1, 1'b1, 32'h10000001, 32'h40000004, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"t5_b1",      1'b0, '0,      3'd0, 1'b1, 1'b1, 32'h20000002, 32'h30000003, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"t5_b2",      1'b0, '0,      3'd0, 1'b1, 1'b1, 32'h30000003, 32'h20000002, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"t5_b3",      1'b0, '0,      3'd0, 1'b1, 1'b1, 32'h40000004, 32'h10000001, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"len1_idle",  1'b1, WORD_T1, 3'd1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0});
    vecs.push_back('{"len1_stall", 1'b0, '0,      3'd0, 1'b0, 1'b1, 32'h00112233, 32'hCCDDEEFF, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"len1_hold",  1'b0, '0,      3'd0, 1'b1, 1'b1, 32'h00112233, 32'hCCDDEEFF, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"len1_done",  1'b0, '0,      3'd0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      checkOutput(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_q_msb, vecs[i].exp_q_lsb,
                  vecs[i].exp_last, vecs[i].exp_ready, vecs[i].exp_busy);
      applyStimulus(vecs[i].in_valid, vecs[i].data, vecs[i].len, vecs[i].out_ready, acc);
    end

    // Back-to-back words with in_valid held high: expect one unbroken run of 12 chunks.
    wl[0] = WORD_T1;
    wl[1] = WORD_A;
    wl[2] = WORD_B;
    idx = 0;
    run = 0;
    started = 1'b0;
    stopped = 1'b0;
    saw_ready_low = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checkModel("b2b");
      if (out_valid_m && !stopped) begin
        run++;
        started = 1'b1;
      end else if (started) begin
        stopped = 1'b1;
      end
      if (!in_ready_m) saw_ready_low = 1'b1;
      applyStimulus(idx < 3, wl[(idx < 3) ? idx : 0], '0, 1'b1, acc);
      if (acc) idx++;
    end
    n_checks++;
    if (run != 12) begin
      n_fail++;
      $display("[TB] FAIL b2b_run: got %0d contiguous chunks, expected 12", run);
    end
    n_checks++;
    if (!saw_ready_low) begin
      n_fail++;
      $display("[TB] FAIL b2b_ready_drop: got in_ready never low, expected a low period");
    end
    drain("b2b_drain", 40);

    // Backpressure with out_ready cycling 1,0,0.
    pat[0] = 1'b1;
    pat[1] = 1'b0;
    pat[2] = 1'b0;
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      checkModel("bp");
      rd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(idx < 4, rd, CW'($urandom_range(0, 7)), pat[c % 3], acc);
      if (acc) idx++;
    end
    drain("bp_drain", 60);

    // Random traffic on both handshakes and random lengths.
    for (int c = 0; c < 500; c++) begin
      checkModel("rand");
      rd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(($urandom % 3) != 0, rd, CW'($urandom_range(0, 7)), ($urandom % 4) != 0, acc);
    end
    drain("rand_drain", 60);

    // Reset mid-word: A half sent, B buffered, then an asynchronous reset.
    checkModel("rst_pre");
    applyStimulus(1'b1, WORD_A, '0, 1'b1, acc);
    checkModel("rst_a0");
    applyStimulus(1'b1, WORD_B, '0, 1'b1, acc);
    checkModel("rst_a1");
    applyStimulus(1'b0, '0, '0, 1'b1, acc);
    checkModel("rst_a2");
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    words.delete();
    m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_held", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    checkModel("rst_release");
    applyStimulus(1'b0, '0, '0, 1'b1, acc);
    checkModel("rst_clean");
    cyc = 0;
    acc = 1'b0;
    while (!acc && (cyc < 5)) begin
      applyStimulus(1'b1, WORD_D, '0, 1'b1, acc);
      cyc++;
    end
    drain("rst_word_d", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
